// File: rtl/pio_bus_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM PIO slave between two requesters.
// Define PIO_ARB_FIXED_PRIO_EN to make requester 0 always win ties (fixed priority).
module pio_bus_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              ack0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              chipselect,
    output logic              write_n,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] writedata,
    input  logic [DATA_W-1:0] readdata
);

    typedef enum logic [1:0] {IDLE, ISSUE, RWAIT, ACK} state_t;

    state_t state, next_state;

    logic              cmd_we;
    logic              cmd_id;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;

    logic              win_id;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    logic              chipselect_d;
    logic              write_n_d;
    logic [ADDR_W-1:0] address_d;
    logic [DATA_W-1:0] writedata_d;
    logic [DATA_W-1:0] rdata_d;
    logic              ack0_d;
    logic              ack1_d;
    logic              busy_d;

`ifdef PIO_ARB_FIXED_PRIO_EN
    // Requester 0 wins whenever it asks; requester 1 only when 0 is idle.
    assign win_id = ~req0;
`else
    logic last_grant;

    // On a tie the requester that was not served last wins.
    assign win_id = (req0 && req1) ? ~last_grant : ~req0;

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= 1'b1;
        end else if (state == ACK) begin
            last_grant <= cmd_id;
        end
    end
`endif

    assign sel_we    = win_id ? we1    : we0;
    assign sel_addr  = win_id ? addr1  : addr0;
    assign sel_wdata = win_id ? wdata1 : wdata0;

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (req0 || req1) next_state = ISSUE;
            ISSUE:   next_state = cmd_we ? ACK : RWAIT;
            RWAIT:   next_state = ACK;
            ACK:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs are registered, so their next values follow next_state; ISSUE is
    // only entered from IDLE, where the freshly selected command is still on sel_*.
    always_comb begin
        chipselect_d = 1'b0;
        write_n_d    = 1'b1;
        address_d    = address;
        writedata_d  = writedata;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        busy_d       = (next_state != IDLE);
        rdata_d      = (state == RWAIT) ? readdata : rdata;
        case (next_state)
            ISSUE: begin
                chipselect_d = 1'b1;
                write_n_d    = ~sel_we;
                address_d    = sel_addr;
                writedata_d  = sel_we ? sel_wdata : '0;
            end
            RWAIT: begin
                chipselect_d = 1'b1;
            end
            ACK: begin
                ack0_d = ~cmd_id;
                ack1_d = cmd_id;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_we    <= 1'b0;
            cmd_id    <= 1'b0;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
        end else if (state == IDLE && (req0 || req1)) begin
            cmd_we    <= sel_we;
            cmd_id    <= win_id;
            cmd_addr  <= sel_addr;
            cmd_wdata <= sel_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            chipselect <= 1'b0;
            write_n    <= 1'b1;
            address    <= '0;
            writedata  <= '0;
            rdata      <= '0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            busy       <= 1'b0;
        end else begin
            chipselect <= chipselect_d;
            write_n    <= write_n_d;
            address    <= address_d;
            writedata  <= writedata_d;
            rdata      <= rdata_d;
            ack0       <= ack0_d;
            ack1       <= ack1_d;
            busy       <= busy_d;
        end
    end

    // cmd_addr / cmd_wdata document the latched command; the issued copy lives
    // in the address/writedata output registers.
    logic unused_cmd;
    assign unused_cmd = ^{cmd_addr, cmd_wdata};

endmodule

// File: doc/pio_bus_arbiter.md
Name: pio_bus_arbiter

Overview:
- Round-robin arbiter that shares one Avalon-MM PIO slave (2-bit address, 32-bit data, registered readdata) between two local requesters.
- Serialises each requester's single read or write into the slave's chipselect/write_n/address/writedata protocol.
- Returns registered read data and a one-cycle acknowledge to the winning requester.
- Sits between two control engines and the PIO slave inside the lab system, in the clk domain.

Parameters:
- DATA_W, 32, data width of writedata/readdata and requester data buses
- ADDR_W, 2, slave word-address width

Ports:
- clk  input  1  system clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- req0  input  1  requester 0 transaction request (level)
- we0  input  1  requester 0: 1 = write, 0 = read
- addr0  input  ADDR_W  requester 0 slave address
- wdata0  input  DATA_W  requester 0 write data
- ack0  output  1  one-cycle completion pulse to requester 0
- req1, we1, addr1, wdata1, ack1  same as above for requester 1
- rdata  output  DATA_W  read data of last completed read; valid while ack0/ack1 is high
- busy  output  1  high whenever the FSM is not in IDLE
- chipselect  output  1  to slave
- write_n  output  1  to slave, active-low write strobe
- address  output  ADDR_W  to slave
- writedata  output  DATA_W  to slave
- readdata  input  DATA_W  from slave; registered, valid the cycle after address is presented

Behaviour:
- Reset values (synchronous, sampled at clk edge while reset=1):
  - state=IDLE; chipselect=0, write_n=1, address=0, writedata=0, rdata=0, ack0=ack1=0, busy=0
  - last_grant=1, so requester 0 wins the first tie
- FSM states IDLE, ISSUE, RWAIT, ACK; all outputs registered.
- IDLE: if any req is high, select a winner and latch its we/addr/wdata and id; next ISSUE. Otherwise stay in IDLE.
  - Only one req high: that requester wins.
  - Both high: the requester not equal to last_grant wins.
- ISSUE (one cycle): chipselect=1, address=latched addr, writedata=latched wdata (read: 0), write_n=~latched we.
  - Write: next ACK.
  - Read: next RWAIT.
- RWAIT (one cycle): chipselect=1, write_n=1, address held. rdata <= readdata at the end of the cycle; next ACK.
- ACK (one cycle): chipselect=0, write_n=1; ack of the winner=1, the other ack=0; last_grant <= winner id; next IDLE.
- Latency from req first sampled high in IDLE (cycle 0): write ack in cycle 2, read ack in cycle 3.
- Requester contract:
  - Hold req/we/addr/wdata stable from assertion until its ack.
  - req still high in the cycle after ack is a new request, so back-to-back traffic is legal.
  - req dropped before ack is a protocol violation; the latched command still completes.
- Minimum spacing between consecutive transactions is one IDLE cycle; with both requesters continuously requesting, grants strictly alternate.
- rdata holds its value until the next read completes; writes do not modify it.
- reset=1 in any state aborts the transaction:
  - next cycle all outputs are at reset values; no ack is issued for the aborted transaction.
  - A write aborted in ISSUE may already have been accepted by the slave.
- ack0 and ack1 are never high in the same cycle; chipselect is never high in IDLE or ACK.

Optional Feature:
- Macro PIO_ARB_FIXED_PRIO_EN.
- Defined: requester 0 always wins when both req are high; last_grant is not used and has no effect. Requester 1 can starve.
- Undefined (default): round-robin as described above.
- Latency and all other timing are identical in both builds.

Test Plan:
- Reset, then req0=1, we0=1, addr0=0, wdata0=32'h1 → cycle 1: chipselect=1, write_n=0, address=0, writedata=32'h1; cycle 2: ack0=1; slave out_port=1 afterwards.
- Slave in_port=1; req1=1, we1=0, addr1=0 → chipselect held high for cycles 1-2; cycle 3: ack1=1, rdata=32'h00000001; ack0 stays 0.
- Both req0 and req1 held high with writes immediately after reset → grant order 0,1,0,1. Each write takes 3 cycles: ISSUE, ACK, IDLE. With PIO_ARB_FIXED_PRIO_EN the order is 0,0,0…
- Read at addr=2 (slave returns 0) after an earlier read returned 1 → rdata=0 at ack; a following write leaves rdata=0.
- reset asserted in RWAIT during a read → next cycle state=IDLE, chipselect=0, ack0=ack1=0, rdata=0; a new req0 afterwards completes normally.
- req0 held high across its ack → second transaction reaches ISSUE 2 cycles after the first ack. busy=0 for exactly one cycle between the two transactions.
